naive_ntt_seq: RTL and testbench
================================

# naive_ntt_seq

Sequential, parametrised naive number-theoretic transform: computes X[k] = Σ_j a[j]·ω^(j·k) mod q for an N-point vector of W-bit coefficients, using one multiply-accumulate per clock. Successor to the combinational 8×8-bit naive NTT, generalised in point count and width, with a start/busy/done handshake and registered outputs. Sits in the NTT datapath as the reference-model transform that faster butterfly engines are checked against.

## Interface
- N, 8, number of points (≥2)
- W, 8, coefficient / modulus / omega width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a transform; sampled only in IDLE
- data_in  in  N*W  input vector; a[i] = data_in[i*W +: W]
- omega  in  W  N-th root of unity ω
- mod  in  W  modulus q
- busy  out  1  high while a transform is in progress
- done  out  1  single-cycle pulse when data_out is valid
- data_out  out  N*W  result vector; X[k] = data_out[k*W +: W]

## Operation
- States: IDLE, MAC, DONE.
- IDLE: on start=1, latch data_in, omega, mod into internal registers; set k=0, j=0, acc=0, f=1, wk=1; go to MAC. Inputs are not used after this edge.
- MAC, one term per cycle: acc ← (acc + a[j]·f) mod q; f ← (f·wk) mod q; j ← j+1.
- At j=N−1: X[k] ← final acc value (including the a[N−1] term) into the result buffer; wk ← (wk·ω) mod q; acc ← 0, f ← 1, j ← 0, k ← k+1. If k=N−1, go to DONE.
- DONE: copy the result buffer to data_out, pulse done, go to IDLE.
- Arithmetic: the product is 2W bits and the sum is 2W+1 bits. Every reduction is full modulo q, so inputs a[j] ≥ q and ω ≥ q are handled correctly. All outputs lie in [0, q−1].
- q < 2 (mod = 0 or 1): the block takes the same state path and latency, and all X[k] = 0. No divide-by-zero is evaluated.
- ω is not checked for primitivity; the block computes the formula as written.
- start while busy, or in the DONE cycle: ignored, not queued.
- data_out holds its value until the next DONE overwrites it.

## Timing
- Reset values: busy=0, done=0, data_out=0, state=IDLE. All internal counters and registers are cleared.
- rst takes priority over every other input in any state. Reset mid-transform aborts the transform, and data_out returns to 0.
- start sampled high at edge E0: busy=1 from E0 through the end of MAC. MAC occupies exactly N·N cycles.
- done=1 and the new data_out are visible in the cycle after edge E0+N·N+1. Latency is N·N+1 cycles, which is 65 for N=8.
- busy=0 in the DONE cycle. The earliest accepted next start is sampled in the cycle after done.
- Throughput: one transform per N·N+2 cycles.

## Test plan
- N=8, W=8, q=17, ω=2, a=[1,0,0,0,0,0,0,0] → X=[1,1,1,1,1,1,1,1]; done exactly 65 cycles after start, one cycle wide.
- Same q and ω, a1=1, all others 0 → X=[1,2,4,8,16,15,13,9]. Repeat with a1=18 (≥q) → identical result.
- Same q and ω, all a[i]=1 → X=[8,0,0,0,0,0,0,0]. Pulse start again at cycles 10 and 64 → ignored, with a single done at 65.
- Start a transform, assert rst at cycle 20 → busy=0, done=0, data_out=0 on the next cycle. A fresh start with the impulse-at-1 vector then gives [1,2,4,8,16,15,13,9] after 65 cycles.
- mod=1 and mod=0, random data → data_out all 0, done at 65 cycles, no X/undefined values.
- Parametrisation N=4, W=16, q=257, ω=16, a1=1 → X=[1,16,256,241], done 17 cycles after start. Random vectors are compared against a software model of the Σ formula.

Source files
------------

// File: rtl/naive_ntt_seq.sv
// Sequential naive NTT: X[k] = sum_j a[j]*omega^(j*k) mod q, one multiply-accumulate per clock.
// Start/busy/done handshake; data_out is registered and holds until the next transform completes.
module naive_ntt_seq #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*W-1:0] data_in,
  input  logic [W-1:0]   omega,
  input  logic [W-1:0]   mod,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] data_out
);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [N*W-1:0]  r_a, r_buf, r_dout;
  logic [W-1:0]    r_omega, r_q, r_acc, r_f, r_wk;
  logic [CW-1:0]   r_j, r_k;
  logic            r_done;

  logic            w_last_j, w_last_k;
  logic [W-1:0]    w_div, w_aj, w_acc_next, w_f_next, w_wk_next;
  logic [2*W-1:0]  w_prod, w_fprod, w_wprod;
  logic [2*W:0]    w_sum;

  // For q < 2 dividing by 1 yields 0 everywhere and avoids a zero divisor.
  function automatic logic [W-1:0] reduce(input logic [2*W:0] x, input logic [W-1:0] d);
    return W'(x % {{(W+1){1'b0}}, d});
  endfunction

  assign w_div      = (r_q < W'(2)) ? W'(1) : r_q;
  assign w_last_j   = (r_j == CW'(N-1));
  assign w_last_k   = (r_k == CW'(N-1));
  assign w_aj       = r_a[W*r_j +: W];
  assign w_prod     = {{W{1'b0}}, w_aj} * {{W{1'b0}}, r_f};
  assign w_sum      = {{(W+1){1'b0}}, r_acc} + {1'b0, w_prod};
  assign w_fprod    = {{W{1'b0}}, r_f} * {{W{1'b0}}, r_wk};
  assign w_wprod    = {{W{1'b0}}, r_wk} * {{W{1'b0}}, r_omega};
  assign w_acc_next = reduce(w_sum, w_div);
  assign w_f_next   = reduce({1'b0, w_fprod}, w_div);
  assign w_wk_next  = reduce({1'b0, w_wprod}, w_div);

  assign done     = r_done;
  assign data_out = r_dout;

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_MAC;
      S_MAC: begin
        busy = 1'b1;
        if (w_last_j && w_last_k) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_buf   <= '0;
      r_dout  <= '0;
      r_omega <= '0;
      r_q     <= '0;
      r_acc   <= '0;
      r_f     <= '0;
      r_wk    <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= data_in;
            r_omega <= omega;
            r_q     <= mod;
            r_acc   <= '0;
            r_f     <= W'(1);
            r_wk    <= W'(1);
            r_j     <= '0;
            r_k     <= '0;
          end
        end
        S_MAC: begin
          if (w_last_j) begin
            r_buf[W*r_k +: W] <= w_acc_next;
            r_acc <= '0;
            r_f   <= W'(1);
            r_wk  <= w_wk_next;
            r_j   <= '0;
            r_k   <= r_k + CW'(1);
          end else begin
            r_acc <= w_acc_next;
            r_f   <= w_f_next;
            r_j   <= r_j + CW'(1);
          end
        end
        S_DONE: begin
          r_dout <= r_buf;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_naive_ntt_seq.sv
// Bench for naive_ntt_seq: an (N=8,W=8) and an (N=4,W=16) instance checked every cycle against
// a direct sum-of-powers model, plus literal vectors for the known transforms.
module tb_naive_ntt_seq;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       st = '0;
  logic [1:0][63:0] din = '0;
  logic [1:0][15:0] om = '0;
  logic [1:0][15:0] qv = '0;
  logic [1:0]       busy_w, done_w;
  logic [1:0][63:0] dout_w;

  int          cyc = 0;
  int          n_tot = 0;
  int          n_pass = 0;
  bit          chk_en = 1'b0;
  int          m_e0 [2];
  logic [63:0] m_old [2];
  logic [63:0] m_new [2];
  int          NN [2] = '{64, 16};

  naive_ntt_seq #(.N(8), .W(8)) dut8 (
    .clk(clk), .rst(rst), .start(st[0]), .data_in(din[0]), .omega(om[0][7:0]),
    .mod(qv[0][7:0]), .busy(busy_w[0]), .done(done_w[0]), .data_out(dout_w[0])
  );
  naive_ntt_seq #(.N(4), .W(16)) dut4 (
    .clk(clk), .rst(rst), .start(st[1]), .data_in(din[1]), .omega(om[1]),
    .mod(qv[1]), .busy(busy_w[1]), .done(done_w[1]), .data_out(dout_w[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // X[k] = sum_j a[j] * om^(j*k) mod q, powers taken directly from the exponent j*k.
  function automatic logic [63:0] model(input logic [63:0] a, input int n, input int w,
                                        input longint unsigned o, input longint unsigned q);
    logic [63:0]       r;
    longint unsigned   s, p, aj, mask;
    r = '0;
    if (q < 2) return r;
    mask = (64'd1 << w) - 1;
    for (int k = 0; k < n; k++) begin
      s = 0;
      for (int j = 0; j < n; j++) begin
        aj = (a >> (j * w)) & mask;
        p = 1;
        for (int e = 0; e < j * k; e++) p = (p * o) % q;
        s = (s + (aj % q) * p) % q;
      end
      r = r | (64'(s) << (k * w));
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        bit          eb, ed;
        logic [63:0] eo;
        eb = (m_e0[d] >= 0) && (cyc >= m_e0[d]) && (cyc < m_e0[d] + NN[d]);
        ed = (m_e0[d] >= 0) && (cyc == m_e0[d] + NN[d] + 1);
        eo = ((m_e0[d] >= 0) && (cyc >= m_e0[d] + NN[d] + 1)) ? m_new[d] : m_old[d];
        chk(d == 0 ? "busy8" : "busy4", 64'(busy_w[d]), 64'(eb));
        chk(d == 0 ? "done8" : "done4", 64'(done_w[d]), 64'(ed));
        chk(d == 0 ? "dout8" : "dout4", dout_w[d], eo);
      end
    end
  end

  task automatic run(input int d, input logic [63:0] a, input logic [15:0] o, input logic [15:0] q,
                     input bit pulses, input int abort_at, input bit use_lit, input logic [63:0] lit);
    int lat;
    bit aborted;
    lat = -1;
    aborted = 1'b0;
    @(negedge clk);
    din[d] = a; om[d] = o; qv[d] = q; st[d] = 1'b1;
    if (m_e0[d] >= 0) m_old[d] = m_new[d];
    @(posedge clk); #1;
    m_e0[d]  = cyc;
    m_new[d] = (d == 0) ? model(a, 8, 8, 64'(o), 64'(q)) : model(a, 4, 16, 64'(o), 64'(q));
    st[d] = 1'b0;
    din[d] = {$urandom, $urandom}; om[d] = 16'($urandom); qv[d] = 16'($urandom);
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (c == abort_at) rst = 1'b1;
      if (abort_at > 0 && c == abort_at + 1) begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
          m_e0[i] = -1; m_old[i] = '0; m_new[i] = '0;
        end
        aborted = 1'b1;
        break;
      end
      st[d] = pulses && (c == 10 || c == NN[d]);
      if (done_w[d]) begin
        lat = c;
        break;
      end
    end
    st[d] = 1'b0;
    if (!aborted) begin
      chk(d == 0 ? "latency8" : "latency4", 64'(lat), 64'(NN[d] + 1));
      if (use_lit) chk(d == 0 ? "literal8" : "literal4", dout_w[d], lit);
    end
  endtask

  initial begin
    logic [63:0] x1;
    x1 = 64'h090D0F10_08040201;
    for (int i = 0; i < 2; i++) begin
      m_e0[i] = -1; m_old[i] = '0; m_new[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    run(0, 64'h01, 16'd2, 16'd17, 1'b0, 0, 1'b1, 64'h0101010101010101);
    run(0, 64'h0100, 16'd2, 16'd17, 1'b0, 0, 1'b1, x1);
    run(0, 64'h1200, 16'd2, 16'd17, 1'b0, 0, 1'b1, x1);
    run(0, 64'h0101010101010101, 16'd2, 16'd17, 1'b1, 0, 1'b1, 64'h08);
    run(0, {$urandom, $urandom}, 16'd3, 16'd17, 1'b0, 20, 1'b0, '0);
    run(0, 64'h0100, 16'd2, 16'd17, 1'b0, 0, 1'b1, x1);
    run(0, {$urandom, $urandom}, 16'($urandom_range(255)), 16'd1, 1'b0, 0, 1'b1, '0);
    run(0, {$urandom, $urandom}, 16'($urandom_range(255)), 16'd0, 1'b0, 0, 1'b1, '0);
    for (int t = 0; t < 6; t++)
      run(0, {$urandom, $urandom}, 16'($urandom_range(255)), 16'($urandom_range(255, 2)),
          1'b0, 0, 1'b0, '0);

    run(1, 64'h0000_0000_0001_0000, 16'd16, 16'd257, 1'b0, 0, 1'b1, 64'h00F1_0100_0010_0001);
    run(1, 64'h0000_0000_0000_0001, 16'd16, 16'd257, 1'b1, 0, 1'b1, 64'h0001_0001_0001_0001);
    for (int t = 0; t < 5; t++)
      run(1, {$urandom, $urandom}, 16'($urandom), 16'($urandom_range(65535, 2)),
          1'b0, 0, 1'b0, '0);
    run(1, {$urandom, $urandom}, 16'($urandom), 16'd0, 1'b0, 0, 1'b1, '0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
